// File: rtl/john_ring_decoder_pkg.sv
// Shared types and code helpers for the Johnson/ring counter receive monitor.
// Helpers work on the default code width JR_N.
package john_ring_pkg;

  localparam int JR_N  = 4;
  localparam int JR_CW = 8;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    LOCK   = 2'd1,
    FAULT  = 2'd2
  } chan_state_t;

  typedef logic [JR_N-1:0] code_t;

  // A Johnson code with msb=1 is the bitwise inverse of a code with msb=0.
  // Both must be a run of ones starting at the LSB.
  function automatic logic johnson_legal(input code_t q);
    code_t t;
    code_t inc;
    t   = q[JR_N-1] ? ~q : q;
    inc = t + code_t'(1);
    return (t & inc) == '0;
  endfunction

  function automatic int johnson_idx(input code_t q);
    int pop;
    pop = $countones(q);
    return q[JR_N-1] ? (2 * JR_N - pop) : pop;
  endfunction

  function automatic code_t johnson_next(input code_t q);
    return {q[JR_N-2:0], ~q[JR_N-1]};
  endfunction

  function automatic logic ring_legal(input code_t q);
    return $onehot(q);
  endfunction

  function automatic int ring_idx(input code_t q);
    int r;
    r = 0;
    for (int i = 0; i < JR_N; i++) begin
      if (q[i]) r = i;
    end
    return r;
  endfunction

  function automatic code_t ring_next(input code_t q);
    return {q[JR_N-2:0], q[JR_N-1]};
  endfunction

endpackage

// File: rtl/john_ring_decoder_if.sv
// Bus between the counter-health consumer and the decoder: clear, both code
// inputs and every per-channel status output.
interface john_ring_decoder_if
  import john_ring_pkg::*;
#(
  parameter int N  = JR_N,
  parameter int CW = JR_CW
);

  logic                     clr;
  logic [N-1:0]             qin1;
  logic [N-1:0]             qin2;
  logic [$clog2(2*N)-1:0]   idx1;
  logic [$clog2(N)-1:0]     idx2;
  logic                     lock1;
  logic                     lock2;
  logic                     step1;
  logic                     step2;
  logic                     err1;
  logic                     err2;
  logic                     fault1;
  logic                     fault2;
  logic [CW-1:0]            ecnt1;
  logic [CW-1:0]            ecnt2;

  modport master (
    output clr, qin1, qin2,
    input  idx1, idx2, lock1, lock2, step1, step2,
    input  err1, err2, fault1, fault2, ecnt1, ecnt2
  );

  modport slave (
    input  clr, qin1, qin2,
    output idx1, idx2, lock1, lock2, step1, step2,
    output err1, err2, fault1, fault2, ecnt1, ecnt2
  );

endinterface

// File: rtl/john_ring_decoder_chan.sv
// One monitored channel: decodes the code, tracks UNLOCK/LOCK/FAULT against the
// last accepted code, and keeps the sticky fault flag and saturating error count.
module john_ring_chan
  import john_ring_pkg::*;
#(
  parameter int MODE = 0,  // 0 = Johnson, 1 = ring
  parameter int N    = JR_N,
  parameter int CW   = JR_CW,
  parameter int IW   = (MODE == 0) ? $clog2(2 * N) : $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [N-1:0]  code_i,
  output logic [IW-1:0] idx_o,
  output logic          lock_o,
  output logic          step_o,
  output logic          err_o,
  output logic          fault_o,
  output logic [CW-1:0] ecnt_o
);

  localparam logic [1:0] ST_UNLOCK = 2'(UNLOCK);
  localparam logic [1:0] ST_LOCK   = 2'(LOCK);
  localparam logic [1:0] ST_FAULT  = 2'(FAULT);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  prev_q,  prev_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          lock_q,  lock_d;
  logic          step_q,  step_d;
  logic          err_q,   err_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] ecnt_q,  ecnt_d;

  logic          code_legal;
  logic [IW-1:0] code_idx;
  logic [N-1:0]  prev_next;

  always_comb begin
    if (MODE == 0) begin
      code_legal = johnson_legal(code_i);
      code_idx   = IW'(johnson_idx(code_i));
      prev_next  = johnson_next(prev_q);
    end else begin
      code_legal = ring_legal(code_i);
      code_idx   = IW'(ring_idx(code_i));
      prev_next  = ring_next(prev_q);
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case below leaves one unassigned and infers a latch.
    state_d = state_q;
    prev_d  = prev_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    fault_d = fault_q;
    ecnt_d  = ecnt_q;

    case (state_q)
      ST_LOCK: begin
        if (code_i == prev_q) begin
          state_d = ST_LOCK;
        end else if (code_i == prev_next) begin
          step_d = 1'b1;
          prev_d = code_i;
          idx_d  = code_idx;
        end else begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          fault_d = 1'b1;
          ecnt_d  = (ecnt_q == '1) ? ecnt_q : ecnt_q + CW'(1);
        end
      end
      default: begin
        // UNLOCK and FAULT both relock silently on any legal code.
        if (code_legal) begin
          state_d = ST_LOCK;
          prev_d  = code_i;
          idx_d   = code_idx;
        end
      end
    endcase

    // Clear beats a coincident error on the count and flag, not on the pulse.
    if (clr_i) begin
      ecnt_d  = '0;
      fault_d = 1'b0;
    end

    lock_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q <= ST_UNLOCK;
      prev_q  <= '0;
      idx_q   <= '0;
      lock_q  <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
      step_q  <= step_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign idx_o   = idx_q;
  assign lock_o  = lock_q;
  assign step_o  = step_q;
  assign err_o   = err_q;
  assign fault_o = fault_q;
  assign ecnt_o  = ecnt_q;

endmodule

// File: rtl/john_ring_decoder.sv
// Receive-side health monitor for john_ring_counter: channel 1 checks the
// Johnson code, channel 2 the ring code. Wiring only.
module john_ring_decoder
  import john_ring_pkg::*;
#(
  parameter int N  = JR_N,
  parameter int CW = JR_CW
) (
  input logic                clk,
  input logic                rst,
  john_ring_decoder_if.slave bus
);

  john_ring_chan #(
    .MODE (0),
    .N    (N),
    .CW   (CW)
  ) u_chan_johnson (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.clr),
    .code_i  (bus.qin1),
    .idx_o   (bus.idx1),
    .lock_o  (bus.lock1),
    .step_o  (bus.step1),
    .err_o   (bus.err1),
    .fault_o (bus.fault1),
    .ecnt_o  (bus.ecnt1)
  );

  john_ring_chan #(
    .MODE (1),
    .N    (N),
    .CW   (CW)
  ) u_chan_ring (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.clr),
    .code_i  (bus.qin2),
    .idx_o   (bus.idx2),
    .lock_o  (bus.lock2),
    .step_o  (bus.step2),
    .err_o   (bus.err2),
    .fault_o (bus.fault2),
    .ecnt_o  (bus.ecnt2)
  );

endmodule

// File: tb/tb_john_ring_decoder.sv
// Directed bench for john_ring_decoder: inputs change 1 ns after a rising edge,
// outputs are compared 1 ns after the following rising edge.
module tb_john_ring_decoder;

  logic clk;
  logic rst;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [3:0] jseq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] rseq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  john_ring_decoder_if #(.N(4), .CW(8)) bus ();

  john_ring_decoder #(.N(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic chk1(input string tag, input int idx, input logic lock,
                      input logic step, input logic err, input logic fault,
                      input int ecnt);
    check({tag, ".idx1"},   32'(bus.idx1),   32'(idx));
    check({tag, ".lock1"},  32'(bus.lock1),  32'(lock));
    check({tag, ".step1"},  32'(bus.step1),  32'(step));
    check({tag, ".err1"},   32'(bus.err1),   32'(err));
    check({tag, ".fault1"}, 32'(bus.fault1), 32'(fault));
    check({tag, ".ecnt1"},  32'(bus.ecnt1),  32'(ecnt));
  endtask

  task automatic chk2(input string tag, input int idx, input logic lock,
                      input logic step, input logic err, input logic fault,
                      input int ecnt);
    check({tag, ".idx2"},   32'(bus.idx2),   32'(idx));
    check({tag, ".lock2"},  32'(bus.lock2),  32'(lock));
    check({tag, ".step2"},  32'(bus.step2),  32'(step));
    check({tag, ".err2"},   32'(bus.err2),   32'(err));
    check({tag, ".fault2"}, 32'(bus.fault2), 32'(fault));
    check({tag, ".ecnt2"},  32'(bus.ecnt2),  32'(ecnt));
  endtask

  initial begin
    // Reset
    rst      = 1'b0;
    bus.clr  = 1'b0;
    bus.qin1 = 4'b0000;
    bus.qin2 = 4'b0000;
    tick();
    chk1("reset", 0, 0, 0, 0, 0, 0);
    chk2("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Full sequences with wrap: Johnson idx 0..7,0,1 and ring idx 0..3,0..3,0,1
    for (int i = 0; i < 10; i++) begin
      bus.qin1 = jseq[i % 8];
      bus.qin2 = rseq[i % 4];
      tick();
      chk1($sformatf("seq%0d", i), i % 8, 1'b1, i > 0, 1'b0, 1'b0, 0);
      chk2($sformatf("seq%0d", i), i % 4, 1'b1, i > 0, 1'b0, 1'b0, 0);
    end

    // Channel 1: step to 0011, then illegal 1011
    bus.qin1 = 4'b0011;
    tick();
    chk1("j_0011", 2, 1, 1, 0, 0, 0);
    bus.qin1 = 4'b1011;
    tick();
    chk1("j_illegal", 2, 0, 0, 1, 1, 1);
    chk2("j_illegal_ch2", 1, 1, 0, 0, 0, 0);
    tick();
    chk1("j_illegal_hold", 2, 0, 0, 0, 1, 1);
    bus.qin1 = 4'b0111;
    tick();
    chk1("j_relock", 3, 1, 0, 0, 1, 1);

    // Channel 2: walk forward to 0001, then skip to 0100, then illegal 0011
    bus.qin2 = 4'b0100;
    tick();
    chk2("r_0100", 2, 1, 1, 0, 0, 0);
    bus.qin2 = 4'b1000;
    tick();
    chk2("r_1000", 3, 1, 1, 0, 0, 0);
    bus.qin2 = 4'b0001;
    tick();
    chk2("r_wrap", 0, 1, 1, 0, 0, 0);
    bus.qin2 = 4'b0100;
    tick();
    chk2("r_skip", 0, 0, 0, 1, 1, 1);
    chk1("r_skip_ch1", 3, 1, 0, 0, 1, 1);
    bus.qin2 = 4'b0011;
    tick();
    chk2("r_illegal_in_fault", 0, 0, 0, 0, 1, 1);

    // Channel 2: hold 0010 for 5 cycles (relock then hold), then step to 0100
    bus.qin2 = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk2($sformatf("r_hold%0d", i), 1, 1, 0, 0, 1, 1);
    end
    bus.qin2 = 4'b0100;
    tick();
    chk2("r_step_after_hold", 2, 1, 1, 0, 1, 1);
    tick();
    chk2("r_step_one_cycle", 2, 1, 0, 0, 1, 1);

    // Clear coinciding with an error on channel 1; clr also clears channel 2
    bus.qin1 = 4'b1011;
    bus.clr  = 1'b1;
    tick();
    bus.clr  = 1'b0;
    chk1("clr_with_err", 3, 0, 0, 1, 0, 0);
    chk2("clr_ch2", 2, 1, 0, 0, 0, 0);

    // 300 forced faults on channel 1: count saturates at 255, err keeps pulsing
    for (int k = 1; k <= 300; k++) begin
      bus.qin1 = 4'b0111;
      tick();
      check($sformatf("sat_relock%0d.lock1", k), 32'(bus.lock1), 32'd1);
      bus.qin1 = 4'b1011;
      tick();
      check($sformatf("sat_err%0d.err1", k), 32'(bus.err1), 32'd1);
      check($sformatf("sat_err%0d.ecnt1", k), 32'(bus.ecnt1),
            (k > 255) ? 32'd255 : 32'(k));
    end
    chk1("saturated", 3, 0, 0, 1, 1, 255);

    // Clear at saturation on an error cycle
    bus.qin1 = 4'b0111;
    tick();
    bus.qin1 = 4'b1011;
    bus.clr  = 1'b1;
    tick();
    bus.clr  = 1'b0;
    chk1("clr_at_sat", 3, 0, 0, 1, 0, 0);

    // Reset while both channels are locked mid-sequence
    bus.qin1 = 4'b0111;
    tick();
    chk1("pre_rst_relock", 3, 1, 0, 0, 0, 0);
    bus.qin1 = 4'b1111;
    bus.qin2 = 4'b1000;
    tick();
    chk1("pre_rst", 4, 1, 1, 0, 0, 0);
    chk2("pre_rst", 3, 1, 1, 0, 0, 0);
    bus.qin1 = 4'b1110;
    bus.qin2 = 4'b0001;
    rst      = 1'b0;
    tick();
    chk1("mid_rst", 0, 0, 0, 0, 0, 0);
    chk2("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk1("post_rst_lock", 5, 1, 0, 0, 0, 0);
    chk2("post_rst_lock", 0, 1, 0, 0, 0, 0);
    bus.qin1 = 4'b1100;
    bus.qin2 = 4'b0010;
    tick();
    chk1("post_rst_step", 6, 1, 1, 0, 0, 0);
    chk2("post_rst_step", 1, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/john_ring_decoder.md
# john_ring_decoder

Receive-side monitor for the 4-bit Johnson and ring counter outputs. Each cycle it samples both code buses and decodes each to a binary position. It tracks lock per channel and flags illegal codes or skipped steps. It sits downstream of `john_ring_counter` (`qout1` drives `qin1`, `qout2` drives `qin2`) and reports counter health to the status logic.

## Interface
- `N`, 4, code width for both channels. The Johnson channel has 2N states and the ring channel has N states.
- `CW`, 8, width of each saturating error counter.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `clr`  input  1  synchronous clear of error counters and sticky fault flags.
- `qin1`  input  N  Johnson code from counter channel 1.
- `qin2`  input  N  ring code from counter channel 2.
- `idx1`  output  $clog2(2N)  decoded Johnson position, 0..2N-1.
- `idx2`  output  $clog2(N)  decoded ring position, 0..N-1.
- `lock1`, `lock2`  output  1  channel is in LOCK.
- `step1`, `step2`  output  1  one-cycle pulse when a legal forward step is accepted.
- `err1`, `err2`  output  1  one-cycle pulse on an illegal code or transition.
- `fault1`, `fault2`  output  1  sticky error flag, cleared only by `clr` or `rst`.
- `ecnt1`, `ecnt2`  output  CW  saturating error count.

## Operation
- Johnson sequence, with q ← {q[N-2:0], ~q[N-1]}: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then wraps to 0000.
  - Legal code: the ones are contiguous from the LSB when msb=0, or contiguous from the MSB when msb=1.
  - idx = popcount(q) when msb=0, and 2N − popcount(q) when msb=1.
- Ring sequence, with q ← {q[N-2:0], q[N-1]}: 0001, 0010, 0100, 1000, then wraps to 0001.
  - Legal code: exactly one bit set. idx = position of that bit.
- Per-channel FSM with states UNLOCK, LOCK and FAULT. Each channel keeps its last accepted code in `prev`.
  - UNLOCK: a legal code goes to LOCK and captures `prev`. An illegal code stays in UNLOCK with no error.
  - LOCK, input equal to `prev` (hold): stay in LOCK, no pulse.
  - LOCK, input is the successor of `prev`: stay in LOCK, pulse `step`, update `prev` and `idx`.
  - LOCK, any other input (illegal code, backward step or skip): go to FAULT, pulse `err`, set `fault`, increment `ecnt`. `idx` holds.
  - FAULT: a legal code goes to LOCK, captures `prev`, and updates `idx` with no `step` pulse. An illegal code stays in FAULT with no further `err`.
- Wrap-around is a legal step. Johnson 1000→0000 gives idx 7→0. Ring 1000→0001 gives idx 3→0.
- `ecnt` saturates at 2^CW − 1. At saturation, `err` still pulses.
- If `clr` and an error occur in the same cycle, `clr` wins: `ecnt`=0 and `fault`=0. The FSM still moves to FAULT and `err` still pulses.
- The two channels are fully independent.

## Timing
- All outputs are registered. Latency from `qin` to `idx`, `lock`, `step` and `err` is 1 cycle.
- Reset values, asserted at the first edge with `rst`=0:
  - FSM = UNLOCK, `prev` = 0, `idx` = 0, `lock` = 0.
  - `step` = 0, `err` = 0, `fault` = 0, `ecnt` = 0.
- Reset mid-operation clears everything at that edge. Relock needs one further legal sample after `rst` returns to 1.
- `step` and `err` are mutually exclusive and last exactly one cycle.
- `lock` rises 1 cycle after the first legal sample and falls 1 cycle after the offending sample.

## Structure
- Package `john_ring_pkg` holds:
  - the `chan_state_t` enum (UNLOCK, LOCK, FAULT) and the default `N`;
  - the functions `johnson_legal`, `johnson_idx`, `johnson_next`, `ring_legal`, `ring_idx` and `ring_next`.
- Sub-module `john_ring_chan`, with parameter `MODE` (0 = Johnson, 1 = ring), is instantiated twice.
  - It contains the FSM, the `prev` register, the error counter and the flags.
  - Top-level `john_ring_decoder` is wiring only.
- Target size is about 150–250 lines total.

## Test plan
- Reset with `qin1`=0000, then release. Drive the full Johnson sequence for 10 cycles.
  - Required: `lock1`=1 from cycle 2; `idx1` runs 0..7 then 0; one `step1` per change; `err1` never asserts.
- Lock channel 1 on 0011, then drive 1011.
  - Required: `err1` pulses once; `fault1`=1; `ecnt1`=1; `lock1`=0; `idx1` holds 2.
  - Then drive 0111: `lock1`=1 and `idx1`=3 with no `step1`.
- Lock channel 2 on 0001, then drive 0100 (a skip).
  - Required: `err2` pulse, `ecnt2`=1.
  - Then drive 0011: no new `err2`, `ecnt2` stays 1.
- Hold `qin2`=0010 for 5 cycles, then drive 0100.
  - Required: no `step2` during the hold; one `step2`; `idx2` goes 1→2.
- Force 300 alternating faults on channel 1 with `clr` asserted on the same cycle as an error.
  - Required: `ecnt1` saturates at 255.
  - On the `clr` cycle: `ecnt1`=0, `fault1`=0, `err1` still pulses.
- Assert `rst`=0 while both channels are locked mid-sequence.
  - Required: all outputs are at reset values next cycle; relock after the first legal sample once `rst`=1.
